arb_mux: RTL
============

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter WIDTH, default 32, data width of every channel.
REQ-002 Parameter N, default 4, number of input channels, legal range 1..16.
REQ-003 Parameter LOCK_EN, default 1; 1 = in_lock honoured, 0 = in_lock ignored.
REQ-004 Derived constant SW = max(1, clog2(N)), width of out_src.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_data  input  N x WIDTH  per-channel data word.
REQ-008 in_valid  input  N  per-channel request.
REQ-009 in_lock  input  N  per-channel "hold grant after this beat".
REQ-010 in_ready  output  N  per-channel accept.
REQ-011 out_data  output  WIDTH  registered selected word.
REQ-012 out_src  output  SW  index of channel that supplied out_data.
REQ-013 out_valid  output  1  out_data/out_src valid.
REQ-014 out_ready  input  1  consumer accept.

Function
REQ-015 Input beat on channel i transfers when in_valid[i] & in_ready[i] at a rising edge; output beat transfers when out_valid & out_ready.
REQ-016 At most one in_ready bit high per cycle; in_ready[i] = grant[i] & (~out_valid | out_ready).
REQ-017 in_ready is combinational from in_valid, lock state, round-robin pointer, out_valid, out_ready; it does not depend on in_data.
REQ-018 Latency: an accepted input beat appears on out_data/out_src with out_valid=1 the following cycle.
REQ-019 Throughput: one beat per cycle sustained while out_ready=1 and any in_valid=1.
REQ-020 Output register states: EMPTY (out_valid=0) and FULL (out_valid=1); EMPTY->FULL on input transfer; FULL->EMPTY on output transfer with no input transfer; FULL->FULL on simultaneous output and input transfer (new word loaded).
REQ-021 While FULL and out_ready=0, out_data, out_src and out_valid are held stable.
REQ-022 Round-robin: pointer p (SW bits) gives highest priority to channel p, then p+1, ... wrapping N-1 -> 0.
REQ-023 On input transfer from channel g, p <= (g+1) mod N; with no transfer p is unchanged.
REQ-024 Lock (LOCK_EN=1): input transfer from g with in_lock[g]=1 sets locked=1, owner=g; transfer with in_lock[g]=0 clears locked.
REQ-025 While locked, grant goes only to owner; if owner in_valid=0 no channel is granted (no fallback).
REQ-026 LOCK_EN=0: locked is tied 0; in_lock has no effect.
REQ-027 No in_valid high: all in_ready=0, p and lock state unchanged.
REQ-028 N=1: grant is in_valid[0]; out_src is always 0; p is constant 0.
REQ-029 in_valid dropped without transfer is tolerated; arbitration recomputes next cycle, no beat lost or duplicated.

Reset
REQ-030 While reset=1 at a rising edge: out_valid=0, out_data=0, out_src=0, p=0, locked=0, owner=0.
REQ-031 in_ready is 0 for all channels in any cycle where reset=1.
REQ-032 Reset mid-operation discards the held output word and any lock; first post-reset grant follows p=0 priority.

Structure
REQ-033 Shared package arb_mux_pkg holds the SW width function and the round-robin next-pointer function.
REQ-034 Arbitration is a sub-module rr_arbiter (N, pointer, lock/owner, valid vector in; one-hot grant and grant index out); datapath and output register stay in arb_mux.
REQ-035 Data selection uses the grant index; no latch inferred; all outputs driven in every branch.

Verification
REQ-036 Reset then in_valid=4'b1111, out_ready=1, data ch i = 0xA0+i -> out_src sequence 0,1,2,3,0 on consecutive cycles, out_data 0xA0,0xA1,0xA2,0xA3,0xA0.
REQ-037 FULL with out_ready=0 for 5 cycles, ch2 valid data 0x1234 -> out_data held, in_ready=0000 throughout; out_ready=1 -> next cycle out_data=0x1234, out_src=2.
REQ-038 Lock: ch1 sends 3 beats in_lock=1,1,0 while ch0,ch3 valid -> out_src 1,1,1 then 2-free order continues 3,0.
REQ-039 Locked owner ch1 drops in_valid for 2 cycles with ch0 valid -> in_ready=0000, out_valid falls to 0, no ch0 beat accepted.
REQ-040 reset asserted while FULL and locked -> next cycle out_valid=0, in_ready=0000; after release with all valid, first out_src=0.
REQ-041 Random in_valid/out_ready for 10k cycles, N=1/3/4 -> scoreboard: every accepted beat output exactly once, in order, with correct out_src.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// Shared helpers for arb_mux: output register states, source index width, round-robin pointer step.
// No logic of its own; imported by arb_mux and rr_arbiter.
package arb_mux_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ostate_t;

  function automatic int sw_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int rr_next(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Round-robin arbiter with optional grant lock to a single owner channel.
// Latency: purely combinational. Backpressure: none here; the caller qualifies grant with output room.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = sw_of(N)
) (
  input  logic [SW-1:0] ptr,
  input  logic          locked,
  input  logic [SW-1:0] owner,
  input  logic [N-1:0]  valid,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx,
  output logic          grant_vld
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    if (locked) begin
      // A locked owner that is idle blocks everyone else rather than falling back.
      for (int c = 0; c < N; c++) begin
        if (int'(owner) == c && valid[c]) begin
          grant[c]  = 1'b1;
          grant_idx = SW'(c);
          grant_vld = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        if (!grant_vld && valid[idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = SW'(idx);
          grant_vld  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 round-robin arbitrating mux with lockable grant and a single registered output stage.
// Latency: 1 cycle input to output. Backpressure: in_ready only while the output register is empty or draining.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int N       = 4,
  parameter int LOCK_EN = 1,
  localparam int SW     = sw_of(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  input  logic [N-1:0]         in_lock,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SW-1:0]        out_src,
  output logic                 out_valid,
  input  logic                 out_ready
);

  ostate_t          state_q, state_d;
  logic [SW-1:0]    p;
  logic             locked;
  logic [SW-1:0]    owner;
  logic [N-1:0]     grant;
  logic [SW-1:0]    grant_idx;
  logic             grant_vld;
  logic             room;
  logic             xfer;
  logic             lock_sel;
  logic [WIDTH-1:0] sel_data;

  rr_arbiter #(.N(N), .SW(SW)) u_arb (
    .ptr       (p),
    .locked    (locked),
    .owner     (owner),
    .valid     (in_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign out_valid = (state_q == ST_FULL);
  assign room      = ~out_valid | out_ready;
  assign in_ready  = reset ? '0 : (grant & {N{room}});
  assign xfer      = grant_vld & room & ~reset;
  assign lock_sel  = |(in_lock & grant);
  assign sel_data  = in_data[int'(grant_idx)*WIDTH +: WIDTH];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (xfer) state_d = ST_FULL;
      ST_FULL: begin
        if (xfer)           state_d = ST_FULL;
        else if (out_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      out_data <= '0;
      out_src  <= '0;
      p        <= '0;
      locked   <= 1'b0;
      owner    <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        out_data <= sel_data;
        out_src  <= grant_idx;
        p        <= SW'(rr_next(int'(grant_idx), N));
        // With locking disabled the lock flag can never be set.
        locked   <= (LOCK_EN != 0) && lock_sel;
        owner    <= grant_idx;
      end
    end
  end

endmodule
